loop_control: RTL and testbench
===============================

# loop_control

Loop sequencer for the Brainfuck pipeline. It resolves `[` and `]` after data fetch, when the current cell value is known. It keeps a return-address stack of open loops and redirects the PC counter on a taken backward branch. On a zero-cell `[`, it scans the instruction stream forward and squashes it until the matching `]`. It sits beside the data-fetch stage and drives the PC counter's load port and the pipeline flush/squash lines.

## Interface
- `IA_WIDTH`, 12: instruction address width; also the width of the skip nesting counter.
- `DEPTH`, 16: return-stack entries; must be a power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `op_valid` in 1: a loop operation is presented.
- `op_close` in 1: 0 = `[`, 1 = `]`; qualified by `op_valid`.
- `op_pc` in IA_WIDTH: address of the presented bracket.
- `op_zero` in 1: current data cell == 0.
- `op_ack` out 1: operation accepted this cycle.
- `scan_valid` in 1: ifetch delivers an opcode this cycle.
- `scan_opcode` in 8: that opcode, as raw ASCII.
- `squash` out 1: discard the current scan opcode.
- `pc_load` out 1: load `pc_d` into the PC counter.
- `pc_d` out IA_WIDTH: branch target.
- `flush` out 1: invalidate all younger pipeline stages.
- `busy` out 1: state ≠ IDLE.
- `err_overflow` out 1: sticky; `[` was taken with the stack full.
- `err_underflow` out 1: sticky; `]` arrived with the stack empty.

## Operation
- **States:** IDLE, SKIP, ERROR.
- **Acceptance:** `op_ack` = (state == IDLE), combinational. An operation is accepted on `op_valid && op_ack`.
- **`[` with `op_zero`=0:**
  - If the stack is not full, push `op_pc` and stay in IDLE.
  - If the stack is full, set `err_overflow` and go to ERROR.
- **`[` with `op_zero`=1:**
  - Load nest = 1, pulse `flush`, go to SKIP.
  - The stack is unchanged.
- **`]` with the stack empty:** set `err_underflow` and go to ERROR. Underflow takes precedence over `op_zero`.
- **`]` with `op_zero`=0:** pulse `pc_load` with `pc_d` = top + 1, pulse `flush`. The stack is unchanged.
- **`]` with `op_zero`=1:** pop the stack. No redirect.
- **SKIP:** on each `scan_valid`, assert `squash` in that same cycle (combinational).
  - `8'h5B` (`[`): nest + 1.
  - `8'h5D` (`]`): nest − 1; when nest becomes 0, return to IDLE.
  - The matching `]` is squashed too.
  - All other opcodes: squashed, nest unchanged.
- **ERROR:** `op_ack` = 0 and `squash` = 1 held until reset; the core stalls.
- **Arithmetic:** `pc_d` = top + 1 modulo 2^IA_WIDTH. Nest is IA_WIDTH bits and cannot exceed the program length.

## Timing
- **Reset values:** state IDLE, stack empty, nest 0; `pc_load`, `flush`, `squash`, `busy`, `err_*` all 0; `pc_d` = 0.
- **Registered pulses:** `pc_load` and `flush` are registered. They are high for exactly one cycle, the cycle after acceptance. `pc_d` is valid during that cycle and holds afterwards.
- **Push/pop:** take effect at the acceptance edge. A `]` accepted the next cycle sees the new top.
- **SKIP entry:** scan opcodes in the acceptance cycle are ignored and not squashed. Counting starts the cycle after acceptance, coincident with `flush`.
- **SKIP exit:** the matching `]` clears nest, and state is IDLE on the following edge. `op_ack` may go high that cycle.
- **Operations during SKIP:** `op_valid` is not acknowledged. The requester holds the operation until `op_ack`.
- **Reset mid-operation:** a reset in SKIP or ERROR, or during a `pc_load` pulse, drops all outputs to their reset values immediately and asynchronously.
- **Stack:** full at DEPTH entries. A push while full never corrupts existing entries.

## Structure
- **Shared constants in `Constants.v`:**
  - `` `OP_LOOP_OPEN `` = 8'h5B, `` `OP_LOOP_CLOSE `` = 8'h5D.
  - `` `LC_IDLE ``, `` `LC_SKIP ``, `` `LC_ERROR `` state codes.
- **One sub-module, `loop_stack`:** parameterised LIFO (width, depth).
  - Ports: push, pop, din, top, empty, full, with async active-low reset of the pointer.
- **Top level** (`loop_control`): FSM, nest counter, and output registers.

## Test plan
- **Taken loop:** `[` at pc 5 with `op_zero`=0, then `]` at pc 9 with `op_zero`=0 → next cycle `pc_load`=1, `pc_d`=6, `flush`=1 for one cycle; stack depth stays 1.
- **Loop exit:** `]` with `op_zero`=1 after one push → no `pc_load`; stack empty.
- **Nested skip:** `[` with `op_zero`=1, then scan `+ [ - ] > ]` → all 6 opcodes squashed; IDLE after the second `]`; nest never exceeds 2.
- **Overflow:** 16 non-zero `[` accepted, a 17th issued → `err_overflow`=1, `op_ack`=0 thereafter, `squash`=1.
- **Underflow:** `]` on an empty stack → `err_underflow`=1, ERROR state, no `pc_load`.
- **Reset mid-skip:** `reset`=0 asynchronously mid-SKIP with nest=3 → `squash`/`busy` low immediately; after release, a `[` with `op_zero`=0 is accepted and pushed.

Source files
------------

// File: rtl/loop_control_pkg.sv
// Shared constants for the Brainfuck loop sequencer: bracket opcodes and FSM state codes.
package loop_control_pkg;

  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;

  localparam logic [1:0] LC_IDLE  = 2'd0;
  localparam logic [1:0] LC_SKIP  = 2'd1;
  localparam logic [1:0] LC_ERROR = 2'd2;

endpackage

// File: rtl/loop_control_stack.sv
// Return-address LIFO for open loops; only the fill count is reset, entries are plain storage.
module loop_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW:0]      count_q, count_d;
  logic [PW-1:0]    top_idx;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Guarded push/pop keep a full or empty stack intact whatever the caller asks for.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_COUNT);
    do_push = push && !full;
    do_pop  = pop && !empty && !push;
    top_idx = count_q[PW-1:0] - PW'(1);
    top     = mem_q[top_idx];
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + (PW+1)'(1);
    end else if (do_pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[count_q[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/loop_control.sv
// Loop sequencer: resolves [ and ] once the cell value is known, redirects the PC on taken
// backward branches and squashes the instruction stream while skipping a zero-cell loop.
module loop_control
  import loop_control_pkg::*;
#(
  parameter int IA_WIDTH = 12,
  parameter int DEPTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic                op_close,
  input  logic [IA_WIDTH-1:0] op_pc,
  input  logic                op_zero,
  output logic                op_ack,
  input  logic                scan_valid,
  input  logic [7:0]          scan_opcode,
  output logic                squash,
  output logic                pc_load,
  output logic [IA_WIDTH-1:0] pc_d,
  output logic                flush,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_underflow
);

  logic [1:0]          state_q, state_d;
  logic [IA_WIDTH-1:0] nest_q, nest_d;
  logic [IA_WIDTH-1:0] target_q, target_d;
  logic                pc_load_q, pc_load_d;
  logic                flush_q, flush_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_underflow_q, err_underflow_d;
  logic                stack_push, stack_pop;
  logic [IA_WIDTH-1:0] stack_top;
  logic                stack_empty, stack_full;

  loop_stack #(.WIDTH(IA_WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stack_push),
    .pop   (stack_pop),
    .din   (op_pc),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_comb begin
    state_d         = state_q;
    nest_d          = nest_q;
    target_d        = target_q;
    pc_load_d       = 1'b0;
    flush_d         = 1'b0;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    stack_push      = 1'b0;
    stack_pop       = 1'b0;
    op_ack          = (state_q == LC_IDLE);
    squash          = (state_q == LC_ERROR) || ((state_q == LC_SKIP) && scan_valid);

    case (state_q)
      LC_IDLE: begin
        if (op_valid) begin
          if (!op_close) begin
            if (op_zero) begin
              nest_d  = IA_WIDTH'(1);
              flush_d = 1'b1;
              state_d = LC_SKIP;
            end else if (stack_full) begin
              err_overflow_d = 1'b1;
              state_d        = LC_ERROR;
            end else begin
              stack_push = 1'b1;
            end
          // An empty stack on ] is fatal regardless of the cell value.
          end else if (stack_empty) begin
            err_underflow_d = 1'b1;
            state_d         = LC_ERROR;
          end else if (op_zero) begin
            stack_pop = 1'b1;
          end else begin
            pc_load_d = 1'b1;
            flush_d   = 1'b1;
            target_d  = stack_top + IA_WIDTH'(1);
          end
        end
      end
      LC_SKIP: begin
        if (scan_valid) begin
          if (scan_opcode == OP_LOOP_OPEN) begin
            nest_d = nest_q + IA_WIDTH'(1);
          end else if (scan_opcode == OP_LOOP_CLOSE) begin
            nest_d = nest_q - IA_WIDTH'(1);
            if (nest_q == IA_WIDTH'(1)) begin
              state_d = LC_IDLE;
            end
          end
        end
      end
      LC_ERROR: begin
        state_d = LC_ERROR;
      end
      default: begin
        state_d = LC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= LC_IDLE;
      nest_q          <= '0;
      target_q        <= '0;
      pc_load_q       <= 1'b0;
      flush_q         <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      nest_q          <= nest_d;
      target_q        <= target_d;
      pc_load_q       <= pc_load_d;
      flush_q         <= flush_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign pc_load       = pc_load_q;
  assign pc_d          = target_q;
  assign flush         = flush_q;
  assign busy          = (state_q != LC_IDLE);
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_loop_control.sv
// Directed bench for loop_control: each step queues its expected outputs and checks them
// mid-cycle, after the preceding rising edge has settled.
module tb_loop_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_close, op_zero, scan_valid;
  logic [11:0] op_pc;
  logic [7:0]  scan_opcode;
  logic        op_ack, squash, pc_load, flush, busy, err_overflow, err_underflow;
  logic [11:0] pc_d;

  typedef struct packed {
    logic        ack;
    logic        sq;
    logic        pl;
    logic        fl;
    logic [11:0] pcd;
    logic        bz;
    logic        eo;
    logic        eu;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  loop_control #(.IA_WIDTH(12), .DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_close      (op_close),
    .op_pc         (op_pc),
    .op_zero       (op_zero),
    .op_ack        (op_ack),
    .scan_valid    (scan_valid),
    .scan_opcode   (scan_opcode),
    .squash        (squash),
    .pc_load       (pc_load),
    .pc_d          (pc_d),
    .flush         (flush),
    .busy          (busy),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic ack, input logic sq, input logic pl, input logic fl,
                              input logic [11:0] pcd, input logic bz, input logic eo, input logic eu);
    mk = {ack, sq, pl, fl, pcd, bz, eo, eu};
  endfunction

  task automatic checkVal(input string tag, input string field, input logic [31:0] obs,
                          input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkVal(tag, "op_ack", 32'(op_ack), 32'(e.ack));
      checkVal(tag, "squash", 32'(squash), 32'(e.sq));
      checkVal(tag, "pc_load", 32'(pc_load), 32'(e.pl));
      checkVal(tag, "flush", 32'(flush), 32'(e.fl));
      checkVal(tag, "pc_d", 32'(pc_d), 32'(e.pcd));
      checkVal(tag, "busy", 32'(busy), 32'(e.bz));
      checkVal(tag, "err_overflow", 32'(err_overflow), 32'(e.eo));
      checkVal(tag, "err_underflow", 32'(err_underflow), 32'(e.eu));
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [11:0] pc, input logic z,
                       input logic sv, input logic [7:0] sop);
    op_valid    = v;
    op_close    = c;
    op_pc       = pc;
    op_zero     = z;
    scan_valid  = sv;
    scan_opcode = sop;
  endtask

  // One cycle: drive, check the settled outputs, then cross the next rising edge.
  task automatic applyStimulus(input string tag, input logic v, input logic c, input logic [11:0] pc,
                               input logic z, input logic sv, input logic [7:0] sop, input exp_t e);
    drive(v, c, pc, z, sv, sop);
    exp_q.push_back(e);
    #1;
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkNow(input string tag, input exp_t e);
    exp_q.push_back(e);
    #1;
    checkOutput(tag);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    drive(0, 0, 12'h0, 0, 0, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 12'h0, 0, 0, 8'h00);
    #2;
    checkNow("reset", mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    releaseReset();

    // Taken loop: [ at 5, ] at 9 redirects to 6
    applyStimulus("open5",    1, 0, 12'd5, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    applyStimulus("close9",   1, 1, 12'd9, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    applyStimulus("redirect", 0, 0, 12'd0, 0, 0, 8'h00, mk(1, 0, 1, 1, 12'd6, 0, 0, 0));
    applyStimulus("pulse_end",0, 0, 12'd0, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd6, 0, 0, 0));
    applyStimulus("close9b",  1, 1, 12'd9, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd6, 0, 0, 0));
    applyStimulus("exit",     1, 1, 12'd9, 1, 0, 8'h00, mk(1, 0, 1, 1, 12'd6, 0, 0, 0));
    applyStimulus("exit_done",0, 0, 12'd0, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd6, 0, 0, 0));

    // Nested skip: scan + [ - ] > ]
    applyStimulus("skip_acc", 1, 0, 12'd20, 1, 1, 8'h2B, mk(1, 0, 0, 0, 12'd6, 0, 0, 0));
    applyStimulus("sk_plus",  0, 0, 12'd0, 0, 1, 8'h2B, mk(0, 1, 0, 1, 12'd6, 1, 0, 0));
    applyStimulus("sk_open",  0, 0, 12'd0, 0, 1, 8'h5B, mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    applyStimulus("sk_minus", 1, 0, 12'd30, 0, 1, 8'h2D, mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    applyStimulus("sk_close1",0, 0, 12'd0, 0, 1, 8'h5D, mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    applyStimulus("sk_gap",   0, 0, 12'd0, 0, 0, 8'h5D, mk(0, 0, 0, 0, 12'd6, 1, 0, 0));
    applyStimulus("sk_gt",    0, 0, 12'd0, 0, 1, 8'h3E, mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    applyStimulus("sk_close2",0, 0, 12'd0, 0, 1, 8'h5D, mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    applyStimulus("sk_idle",  0, 0, 12'd0, 0, 1, 8'h2B, mk(1, 0, 0, 0, 12'd6, 0, 0, 0));

    // Reset asynchronously mid-skip at nest 3
    applyStimulus("rs_acc",   1, 0, 12'd40, 1, 0, 8'h00, mk(1, 0, 0, 0, 12'd6, 0, 0, 0));
    applyStimulus("rs_open1", 0, 0, 12'd0, 0, 1, 8'h5B, mk(0, 1, 0, 1, 12'd6, 1, 0, 0));
    applyStimulus("rs_open2", 0, 0, 12'd0, 0, 1, 8'h5B, mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    drive(0, 0, 12'd0, 0, 1, 8'h2B);
    checkNow("rs_nest3", mk(0, 1, 0, 0, 12'd6, 1, 0, 0));
    #2;
    reset = 1'b0;
    checkNow("rs_async", mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    releaseReset();
    applyStimulus("rs_push7", 1, 0, 12'd7, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    applyStimulus("rs_close", 1, 1, 12'd8, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    applyStimulus("rs_redir", 1, 1, 12'd8, 1, 0, 8'h00, mk(1, 0, 1, 1, 12'd8, 0, 0, 0));

    // Target wraps modulo 2^12
    applyStimulus("wr_open",  1, 0, 12'hFFF, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd8, 0, 0, 0));
    applyStimulus("wr_close", 1, 1, 12'd9, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'd8, 0, 0, 0));
    applyStimulus("wr_redir", 1, 1, 12'd9, 1, 0, 8'h00, mk(1, 0, 1, 1, 12'h000, 0, 0, 0));
    applyStimulus("wr_done",  0, 0, 12'd0, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'h000, 0, 0, 0));

    // Overflow: 16 pushes fill the stack, the 17th errors
    for (int i = 0; i < 16; i++) begin
      applyStimulus("ov_push", 1, 0, 12'(100 + i), 0, 0, 8'h00, mk(1, 0, 0, 0, 12'h000, 0, 0, 0));
    end
    applyStimulus("ov_17th",  1, 0, 12'd200, 0, 0, 8'h00, mk(1, 0, 0, 0, 12'h000, 0, 0, 0));
    applyStimulus("ov_err",   0, 0, 12'd0, 0, 0, 8'h00, mk(0, 1, 0, 0, 12'h000, 1, 1, 0));
    applyStimulus("ov_hold",  1, 1, 12'd9, 0, 0, 8'h00, mk(0, 1, 0, 0, 12'h000, 1, 1, 0));
    drive(0, 0, 12'd0, 0, 0, 8'h00);
    reset = 1'b0;
    checkNow("ov_reset", mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    releaseReset();

    // Underflow on empty stack wins over op_zero
    applyStimulus("un_close", 1, 1, 12'd50, 1, 0, 8'h00, mk(1, 0, 0, 0, 12'd0, 0, 0, 0));
    applyStimulus("un_err",   0, 0, 12'd0, 0, 0, 8'h00, mk(0, 1, 0, 0, 12'd0, 1, 0, 1));
    applyStimulus("un_hold",  0, 0, 12'd0, 0, 0, 8'h00, mk(0, 1, 0, 0, 12'd0, 1, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
